// File: rtl/ram_arbiter_pkg.sv
// Shared types for the IF/MEM RAM port arbiter.
// Optional fairness feature: RAM_ARB_FAIR_EN.
package ram_arbiter_pkg;

    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;
    localparam int STARVE_W = 3;

    typedef logic [ADDR_W-1:0]   ram_addr_t;
    typedef logic [DATA_W-1:0]   ram_data_t;
    typedef logic [STARVE_W-1:0] arb_starve_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_RESP_IF  = 2'd1,
        ARB_RESP_MEM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_arb_prio.sv
// Combinational grant logic: MEM over IF, acked requester masked.
// With RAM_ARB_FAIR_EN a starvation flag hands contested grants to IF.
module ram_arb_prio
    import ram_arbiter_pkg::*;
(
    input  logic if_req_i,
    input  logic mem_req_i,
    input  logic if_mask_i,
    input  logic mem_mask_i,
`ifdef RAM_ARB_FAIR_EN
    input  logic starve_i,
`endif
    output logic grant_if_o,
    output logic grant_mem_o
);

    logic if_req;
    logic mem_req;

    assign if_req  = if_req_i & ~if_mask_i;
    assign mem_req = mem_req_i & ~mem_mask_i;

    always_comb begin
        grant_mem_o = mem_req;
        grant_if_o  = if_req & ~mem_req;
`ifdef RAM_ARB_FAIR_EN
        if (starve_i && if_req && mem_req) begin
            grant_if_o  = 1'b1;
            grant_mem_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between IF and MEM with a fixed one-cycle response.
// Define RAM_ARB_FAIR_EN to bound IF starvation by STARVE_MAX MEM grants.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [DATA_W-1:0] mem_wmask_i,
    output logic              mem_ack_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              ram_r_ena_o,
    output logic [ADDR_W-1:0] ram_r_addr_o,
    input  logic [DATA_W-1:0] ram_r_data_i,
    output logic              ram_w_ena_o,
    output logic [ADDR_W-1:0] ram_w_addr_o,
    output logic [DATA_W-1:0] ram_w_data_o,
    output logic [DATA_W-1:0] ram_w_mask_o,
    output logic              arb_busy_o
);

    arb_state_e state_q, state_d;
    logic       we_q, we_d;
    logic       grant_if;
    logic       grant_mem;

`ifdef RAM_ARB_FAIR_EN
    localparam arb_starve_t STARVE_LIM = arb_starve_t'(STARVE_MAX);

    arb_starve_t starve_q, starve_d;
    logic        starve_hit;

    assign starve_hit = (starve_q >= STARVE_LIM);

    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || grant_if) begin
            starve_d = '0;
        end else if (grant_mem && starve_q != '1) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    ram_arb_prio u_prio (
        .if_req_i    (if_req_i),
        .mem_req_i   (mem_req_i),
        .if_mask_i   (state_q == ARB_RESP_IF),
        .mem_mask_i  (state_q == ARB_RESP_MEM),
`ifdef RAM_ARB_FAIR_EN
        .starve_i    (starve_hit),
`endif
        .grant_if_o  (grant_if),
        .grant_mem_o (grant_mem)
    );

    always_comb begin
        state_d = ARB_IDLE;
        we_d    = 1'b0;
        if (grant_mem) begin
            state_d = ARB_RESP_MEM;
            we_d    = mem_we_i;
        end else if (grant_if) begin
            state_d = ARB_RESP_IF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
        end
    end

    // RAM strobes are gated by reset so nothing reaches the RAM while held.
    always_comb begin
        ram_r_ena_o  = 1'b0;
        ram_r_addr_o = '0;
        ram_w_ena_o  = 1'b0;
        ram_w_addr_o = '0;
        ram_w_data_o = '0;
        ram_w_mask_o = '0;
        if (rst) begin
            if (grant_mem && mem_we_i) begin
                ram_w_ena_o  = 1'b1;
                ram_w_addr_o = mem_addr_i;
                ram_w_data_o = mem_wdata_i;
                ram_w_mask_o = mem_wmask_i;
            end else if (grant_mem) begin
                ram_r_ena_o  = 1'b1;
                ram_r_addr_o = mem_addr_i;
            end else if (grant_if) begin
                ram_r_ena_o  = 1'b1;
                ram_r_addr_o = if_addr_i;
            end
        end
    end

    assign if_ack_o    = (state_q == ARB_RESP_IF);
    assign mem_ack_o   = (state_q == ARB_RESP_MEM);
    assign arb_busy_o  = (state_q != ARB_IDLE);
    assign if_rdata_o  = if_ack_o ? ram_r_data_i : '0;
    assign mem_rdata_o = (mem_ack_o && !we_q) ? ram_r_data_i : '0;

endmodule
